// File: rtl/bus_arbiter_if.sv
// Arbiter bus bundle: per-master requests, the shared slave busy line, and the grant outputs.
// The arbiter connects to the slave modport. Masters and slaves connect to the master modport.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ID_WIDTH    = 2
);
  logic [NUM_MASTERS-1:0] m_req;
  logic                   slave_busy;
  logic [NUM_MASTERS-1:0] m_grant;
  logic                   bus_util;
  logic [ID_WIDTH-1:0]    grant_id;
  logic                   timeout_err;

  modport master (
    output m_req, slave_busy,
    input  m_grant, bus_util, grant_id, timeout_err
  );

  modport slave (
    input  m_req, slave_busy,
    output m_grant, bus_util, grant_id, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus.
// It grants one cycle after arbitration, holds the grant while the slave is busy, and revokes a grant that exceeds its budget.
module bus_arbiter #(
  parameter int                       NUM_MASTERS    = 3,
  parameter int                       ID_WIDTH       = 2,
  parameter int                       TIMEOUT_WIDTH  = 12,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 12'd2000
) (
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, TURN} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
  localparam bit                       TO_EN   = (TIMEOUT_CYCLES != '0);

  state_t                  state;
  logic [TIMEOUT_WIDTH-1:0] hold_cnt;
  logic [NUM_MASTERS-1:0]  mask;
  logic [ID_WIDTH-1:0]     last_winner;

  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  win_oh;
  logic [ID_WIDTH-1:0]     win_id;
  logic                    win_vld;
  logic                    owner_req;

  // Visit masters in order starting after last_winner. The first eligible master found wins.
  always_comb begin
    eligible = bus.m_req & ~mask;
    win_oh   = '0;
    win_id   = '0;
    win_vld  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!win_vld && eligible[i] && (i == (int'(last_winner) + k) % NUM_MASTERS)) begin
          win_vld   = 1'b1;
          win_id    = ID_WIDTH'(i);
          win_oh[i] = 1'b1;
        end
      end
    end
  end

  assign owner_req = |(bus.m_req & bus.m_grant);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      bus.m_grant     <= '0;
      bus.bus_util    <= 1'b0;
      bus.grant_id    <= '0;
      bus.timeout_err <= 1'b0;
      hold_cnt        <= '0;
      mask            <= '0;
      last_winner     <= ID_WIDTH'(NUM_MASTERS - 1);
    end else begin
      bus.timeout_err <= 1'b0;
      mask            <= mask & bus.m_req;
      case (state)
        IDLE, TURN: begin
          if (win_vld) begin
            state        <= ACTIVE;
            bus.m_grant  <= win_oh;
            bus.bus_util <= 1'b1;
            bus.grant_id <= win_id;
            last_winner  <= win_id;
            hold_cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + TIMEOUT_WIDTH'(1);
          if (!owner_req && !bus.slave_busy) begin
            state        <= TURN;
            bus.m_grant  <= '0;
            bus.bus_util <= 1'b0;
          end else if (TO_EN && hold_cnt == TO_LAST) begin
            // The revoked master stays ineligible until it drops its request.
            state           <= TURN;
            bus.m_grant     <= '0;
            bus.bus_util    <= 1'b0;
            bus.timeout_err <= 1'b1;
            mask            <= (mask & bus.m_req) | bus.m_grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter. Two instances share the same stimulus: one with an 8-cycle timeout and one with the timeout disabled.
// Both instances are compared against a cycle-level model built from the arbitration rules.
module tb_bus_arbiter;
  localparam int NM   = 3;
  localparam int IW   = 2;
  localparam int VW   = NM + 1 + IW + 1;
  localparam int TO_A = 8;
  localparam int TO_B = 0;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [NM-1:0] req  = '0;
  logic          busy = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(NM), .ID_WIDTH(IW)) bus_a ();
  bus_arbiter_if #(.NUM_MASTERS(NM), .ID_WIDTH(IW)) bus_b ();

  assign bus_a.m_req      = req;
  assign bus_a.slave_busy = busy;
  assign bus_b.m_req      = req;
  assign bus_b.slave_busy = busy;

  bus_arbiter #(.NUM_MASTERS(NM), .ID_WIDTH(IW), .TIMEOUT_WIDTH(12), .TIMEOUT_CYCLES(12'(TO_A)))
    dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  bus_arbiter #(.NUM_MASTERS(NM), .ID_WIDTH(IW), .TIMEOUT_WIDTH(12), .TIMEOUT_CYCLES(12'(TO_B)))
    dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  logic [NM-1:0] a_grant [2];
  logic          a_to    [2];
  logic [VW-1:0] a_vec   [2];
  assign a_grant[0] = bus_a.m_grant;
  assign a_grant[1] = bus_b.m_grant;
  assign a_to[0]    = bus_a.timeout_err;
  assign a_to[1]    = bus_b.timeout_err;
  assign a_vec[0]   = {bus_a.m_grant, bus_a.bus_util, bus_a.grant_id, bus_a.timeout_err};
  assign a_vec[1]   = {bus_b.m_grant, bus_b.bus_util, bus_b.grant_id, bus_b.timeout_err};

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the current owner (-1 means none), the number of cycles it has held the bus, and per-master masks.
  int            to_cfg [2] = '{TO_A, TO_B};
  int            own    [2];
  int            held   [2];
  int            last   [2];
  int            gid    [2];
  bit            msk    [2][NM];
  bit            tpulse [2];
  logic [VW-1:0] m_exp  [2];

  function automatic void model_step();
    for (int c = 0; c < 2; c++) begin
      int            tmo;
      logic [NM-1:0] g;
      tmo       = -1;
      tpulse[c] = 1'b0;
      if (!rstn) begin
        own[c]  = -1;
        held[c] = 0;
        last[c] = NM - 1;
        gid[c]  = 0;
        for (int i = 0; i < NM; i++) msk[c][i] = 1'b0;
      end else begin
        if (own[c] >= 0) begin
          held[c]++;
          if (!req[own[c]] && !busy) begin
            own[c] = -1;
          end else if (to_cfg[c] != 0 && held[c] >= to_cfg[c]) begin
            tmo       = own[c];
            own[c]    = -1;
            tpulse[c] = 1'b1;
          end
        end else begin
          for (int k = 1; k <= NM; k++) begin
            int i;
            i = (last[c] + k) % NM;
            if (own[c] < 0 && req[i] && !msk[c][i]) begin
              own[c]  = i;
              last[c] = i;
              gid[c]  = i;
              held[c] = 0;
            end
          end
        end
        for (int i = 0; i < NM; i++) if (!req[i]) msk[c][i] = 1'b0;
        if (tmo >= 0) msk[c][tmo] = 1'b1;
      end
      g = '0;
      if (own[c] >= 0) g[own[c]] = 1'b1;
      m_exp[c] = {g, (own[c] >= 0), IW'(gid[c]), tpulse[c]};
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic drain();
    req  = '0;
    busy = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = '0;
    busy = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (a_vec[c] !== '0) begin
        n_err++;
        $display("FAIL reset_state cfg%0d got %b want %b", c, a_vec[c], {VW{1'b0}});
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    req = 3'b001;
    tick();
    n_cmp++;
    if (a_vec[0] !== {3'b001, 1'b1, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL single_grant got %b want %b", a_vec[0], {3'b001, 1'b1, 2'd0, 1'b0});
    end
    repeat (4) tick();
    n_cmp++;
    if (a_grant[0] !== 3'b001) begin
      n_err++;
      $display("FAIL single_hold got %b want 001", a_grant[0]);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (a_vec[0] !== {3'b000, 1'b0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL single_turn got %b want %b", a_vec[0], {3'b000, 1'b0, 2'd0, 1'b0});
    end
    drain();
  endtask

  task automatic test_contention();
    logic [NM-1:0] seq [4];
    int            rise_t [4];
    int            since [NM];
    int            nseq;
    logic [NM-1:0] prev;
    nseq = 0;
    prev = '0;
    for (int i = 0; i < NM; i++) since[i] = -1;
    rstn = 1'b0;
    tick();
    req  = 3'b111;
    rstn = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_vec[c] !== m_exp[c]) begin
          n_err++;
          $display("FAIL contention_model cfg%0d t=%0d got %b want %b", c, t, a_vec[c], m_exp[c]);
        end
      end
      if (a_grant[0] != '0 && prev == '0 && nseq < 4) begin
        seq[nseq]    = a_grant[0];
        rise_t[nseq] = t;
        nseq++;
      end
      prev = a_grant[0];
      for (int i = 0; i < NM; i++) begin
        if (a_grant[0][i] && since[i] < 0) since[i] = 0;
        else if (since[i] >= 0) since[i]++;
        if (since[i] == 4) req[i] = 1'b0;
        if (since[i] == 5) begin
          req[i]   = 1'b1;
          since[i] = -1;
        end
      end
    end
    n_cmp++;
    if (nseq != 4) begin
      n_err++;
      $display("FAIL contention_count got %0d grants want 4", nseq);
    end else begin
      logic [NM-1:0] want [4];
      want = '{3'b001, 3'b010, 3'b100, 3'b001};
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (seq[j] !== want[j]) begin
          n_err++;
          $display("FAIL contention_order%0d got %b want %b", j, seq[j], want[j]);
        end
      end
      for (int j = 1; j < 4; j++) begin
        n_cmp++;
        if (rise_t[j] - rise_t[j-1] != 6) begin
          n_err++;
          $display("FAIL contention_spacing%0d got %0d want 6", j, rise_t[j] - rise_t[j-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_busy_hold();
    bit got;
    got = 1'b0;
    req = 3'b010;
    for (int t = 0; t < 4 && !got; t++) begin
      tick();
      if (a_grant[0] === 3'b010) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL busy_grant_timeout got %b want 010", a_grant[0]);
    end
    req  = 3'b000;
    busy = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if (a_grant[0] !== 3'b010 || bus_a.bus_util !== 1'b1) begin
        n_err++;
        $display("FAIL busy_hold%0d got %b want 010", t, a_grant[0]);
      end
    end
    busy = 1'b0;
    tick();
    n_cmp++;
    if (a_grant[0] !== 3'b000 || bus_a.bus_util !== 1'b0) begin
      n_err++;
      $display("FAIL busy_release got %b want 000", a_grant[0]);
    end
    drain();
  endtask

  task automatic test_timeout();
    bit got;
    int cnt001, pulses, to_t, first100, bad;
    got = 1'b0;
    cnt001 = 1; pulses = 0; to_t = -1; first100 = -1; bad = 0;
    req = 3'b001;
    for (int t = 0; t < 4 && !got; t++) begin
      tick();
      if (a_grant[0] === 3'b001) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL timeout_first_grant got %b want 001", a_grant[0]);
    end
    req = 3'b101;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (a_grant[0] === 3'b001) cnt001++;
      if (a_to[0] === 1'b1) begin
        pulses++;
        to_t = t;
      end
      if (a_grant[0] === 3'b100 && first100 < 0) first100 = t;
    end
    n_cmp++;
    if (cnt001 != TO_A) begin
      n_err++;
      $display("FAIL timeout_hold_len got %0d want %0d", cnt001, TO_A);
    end
    n_cmp++;
    if (pulses != 1 || to_t != TO_A) begin
      n_err++;
      $display("FAIL timeout_pulse got %0d pulses at %0d want 1 at %0d", pulses, to_t, TO_A);
    end
    n_cmp++;
    if (first100 != TO_A + 1) begin
      n_err++;
      $display("FAIL timeout_next_grant got %0d want %0d", first100, TO_A + 1);
    end
    req = 3'b001;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (a_grant[0] === 3'b001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL timeout_mask got %0d regrants want 0", bad);
    end
    req = 3'b000;
    tick();
    req = 3'b001;
    got = 1'b0;
    for (int t = 0; t < 4 && !got; t++) begin
      tick();
      if (a_grant[0] === 3'b001) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL timeout_unmask got %b want 001", a_grant[0]);
    end
    drain();
  endtask

  task automatic test_no_timeout();
    bit got;
    int bad;
    got = 1'b0;
    bad = 0;
    req = 3'b001;
    for (int t = 0; t < 4 && !got; t++) begin
      tick();
      if (a_grant[1] === 3'b001) got = 1'b1;
    end
    for (int t = 0; t < 5000; t++) begin
      tick();
      if (a_grant[1] !== 3'b001 || a_to[1] !== 1'b0) bad++;
    end
    n_cmp++;
    if (!got || bad != 0) begin
      n_err++;
      $display("FAIL no_timeout_hold got %0d bad cycles (granted=%0d) want 0", bad, got);
    end
    drain();
  endtask

  task automatic test_random();
    bit did_rst;
    did_rst = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        n_cmp++;
        if (a_vec[c] !== m_exp[c]) begin
          n_err++;
          $display("FAIL rand_model cfg%0d t=%0d got %b want %b", c, t, a_vec[c], m_exp[c]);
        end
      end
      if (rstn == 1'b0) begin
        rstn = 1'b1;
      end else if (!did_rst && t >= 1000 && a_grant[0] != '0) begin
        did_rst = 1'b1;
        #2 rstn = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
          n_cmp++;
          if (a_vec[c] !== '0) begin
            n_err++;
            $display("FAIL async_reset cfg%0d got %b want %b", c, a_vec[c], {VW{1'b0}});
          end
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (req[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req[i] = 1'b1;
        end
      end
      busy = ($urandom_range(3) == 0);
    end
    n_cmp++;
    if (!did_rst) begin
      n_err++;
      $display("FAIL async_reset_reached got 0 want 1");
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_busy_hold();
    test_timeout();
    test_no_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
